serial_word_collector: RTL and testbench

Downstream consumer of the 4-bit shifting register's serial output.
- Samples the register's S_OUT bit stream on each enabled clock edge and frames it as a start bit, WIDTH data bits and a stop bit.
- Assembles each frame into a parallel word and presents it with a VALID/ACK handshake.
- Flags framing errors and overruns.
- Lets the test benches and later stages check whole shifted-out words instead of single bits.

---
 rtl/serial_word_collector.sv | 112 +++++++++++
 tb/tb_serial_word_collector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Frames a serial bit stream (start bit, WIDTH data bits, stop bit) into parallel words.
// Completed words are presented with a VALID/ACK handshake; overruns and bad stop bits are flagged.
module serial_word_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             DIR,
  input  logic             ACK,
  output logic [WIDTH-1:0] WORD,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             good_stop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    buf_d       = buf_q;
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    good_stop   = 1'b0;

    if (ENB) begin
      unique case (state_q)
        StIdle: begin
          if (S_IN) begin
            dir_d   = DIR;
            cnt_d   = '0;
            state_d = StData;
          end
        end
        StData: begin
          // dir_q=1: LSB first, so the first bit ends up at bit 0 after WIDTH shifts.
          buf_d = dir_q ? {S_IN, buf_q[WIDTH-1:1]} : {buf_q[WIDTH-2:0], S_IN};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StStop;
          end
        end
        StStop: begin
          state_d = StIdle;
          if (S_IN) begin
            frame_err_d = 1'b1;
          end else begin
            good_stop = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Handshake runs every edge; a new word wins over an ACK on the same edge.
    if (good_stop) begin
      word_d    = buf_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~ACK;
    end else if (ACK && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      buf_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      buf_q       <= buf_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign WORD      = word_q;
  assign VALID     = valid_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: framing, bit order, ENB gaps, handshake and reset.
module tb_serial_word_collector;

  logic       CLK = 1'b0;
  logic       RST_L;
  logic       ENB;
  logic       S_IN;
  logic       DIR;
  logic       ACK;
  logic [7:0] WORD;
  logic       VALID;
  logic       OVERRUN;
  logic       FRAME_ERR;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  serial_word_collector #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RST_L    (RST_L),
    .ENB      (ENB),
    .S_IN     (S_IN),
    .DIR      (DIR),
    .ACK      (ACK),
    .WORD     (WORD),
    .VALID    (VALID),
    .OVERRUN  (OVERRUN),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one clock edge, then settle 1 time unit past it before any sampling.
  task automatic tick(input logic enb, input logic sin);
    ENB  = enb;
    S_IN = sin;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input logic dir);
    for (int i = 0; i < 8; i++) tick(1'b1, dir ? w[i] : w[7-i]);
  endtask

  task automatic test_reset();
    RST_L = 1'b0; ENB = 1'b0; S_IN = 1'b0; DIR = 1'b0; ACK = 1'b0;
    #2;
    n_checks++;
    if ({WORD, VALID, OVERRUN, FRAME_ERR, BUSY} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000", {WORD, VALID, OVERRUN, FRAME_ERR, BUSY});
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_busy: got %0b expected 0", BUSY);
    end
    RST_L = 1'b1;
  endtask

  task automatic test_frame_err();
    DIR = 1'b1;
    tick(1'b1, 1'b1);
    send_bits(8'hA5, 1'b1);
    tick(1'b1, 1'b1);
    n_checks++;
    if (FRAME_ERR !== 1'b1) begin
      n_fail++; $display("FAIL ferr_pulse: got %0b expected 1", FRAME_ERR);
    end
    n_checks++;
    if ({WORD, VALID, BUSY} !== 10'h000) begin
      n_fail++; $display("FAIL ferr_word_valid_busy: got %h expected 000", {WORD, VALID, BUSY});
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if ({FRAME_ERR, BUSY, VALID} !== 3'b000) begin
      n_fail++; $display("FAIL ferr_after: got %b expected 000", {FRAME_ERR, BUSY, VALID});
    end
  endtask

  task automatic test_lsb_first();
    DIR = 1'b1;
    tick(1'b1, 1'b1);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL lsb_busy_start: got %0b expected 1", BUSY);
    end
    send_bits(8'hA5, 1'b1);
    n_checks++;
    if ({BUSY, VALID} !== 2'b10) begin
      n_fail++; $display("FAIL lsb_pre_stop: got %b expected 10", {BUSY, VALID});
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if ({WORD, VALID, OVERRUN, FRAME_ERR, BUSY} !== {8'hA5, 4'b1000}) begin
      n_fail++;
      $display("FAIL lsb_word: got %h expected a58", {WORD, VALID, OVERRUN, FRAME_ERR, BUSY});
    end
    ACK = 1'b1;
    tick(1'b0, 1'b0);
    ACK = 1'b0;
    n_checks++;
    if ({VALID, WORD} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL lsb_ack: got %h expected 0a5", {VALID, WORD});
    end
  endtask

  task automatic test_msb_gaps();
    logic [7:0] w;
    w   = 8'hA5;
    DIR = 1'b0;
    tick(1'b1, 1'b1);
    DIR = 1'b1;  // must be ignored: order is captured at the start bit
    for (int i = 0; i < 4; i++) tick(1'b1, w[7-i]);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n_checks++;
    if ({BUSY, VALID} !== 2'b10) begin
      n_fail++; $display("FAIL msb_gap_hold: got %b expected 10", {BUSY, VALID});
    end
    for (int i = 4; i < 8; i++) tick(1'b1, w[7-i]);
    n_checks++;
    if (VALID !== 1'b0) begin
      n_fail++; $display("FAIL msb_edge12_valid: got %0b expected 0", VALID);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if ({WORD, VALID, BUSY} !== {8'hA5, 2'b10}) begin
      n_fail++; $display("FAIL msb_word: got %h expected 296", {WORD, VALID, BUSY});
    end
    ACK = 1'b1;
    tick(1'b1, 1'b0);
    ACK = 1'b0;
  endtask

  task automatic test_overrun();
    DIR = 1'b1;
    tick(1'b1, 1'b1); send_bits(8'h3C, 1'b1); tick(1'b1, 1'b0);
    n_checks++;
    if ({WORD, VALID, OVERRUN} !== {8'h3C, 2'b10}) begin
      n_fail++; $display("FAIL ovr_first: got %h expected 0f2", {WORD, VALID, OVERRUN});
    end
    tick(1'b1, 1'b1); send_bits(8'hC3, 1'b1); tick(1'b1, 1'b0);
    n_checks++;
    if ({WORD, VALID, OVERRUN} !== {8'hC3, 2'b11}) begin
      n_fail++; $display("FAIL ovr_second: got %h expected 30f", {WORD, VALID, OVERRUN});
    end
    ACK = 1'b1;
    tick(1'b0, 1'b0);
    ACK = 1'b0;
    n_checks++;
    if ({VALID, OVERRUN} !== 2'b00) begin
      n_fail++; $display("FAIL ovr_ack_clear: got %b expected 00", {VALID, OVERRUN});
    end
    ACK = 1'b1;
    tick(1'b0, 1'b0);
    ACK = 1'b0;
    n_checks++;
    if ({VALID, OVERRUN} !== 2'b00) begin
      n_fail++; $display("FAIL ack_when_idle: got %b expected 00", {VALID, OVERRUN});
    end
    tick(1'b1, 1'b1); send_bits(8'h3C, 1'b1); tick(1'b1, 1'b0);
    tick(1'b1, 1'b1); send_bits(8'hC3, 1'b1);
    ACK = 1'b1;
    tick(1'b1, 1'b0);
    ACK = 1'b0;
    n_checks++;
    if ({WORD, VALID, OVERRUN} !== {8'hC3, 2'b10}) begin
      n_fail++; $display("FAIL ack_collision: got %h expected 30e", {WORD, VALID, OVERRUN});
    end
  endtask

  task automatic test_reset_mid_frame();
    DIR = 1'b1;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    n_checks++;
    if ({VALID, BUSY} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre: got %b expected 11", {VALID, BUSY});
    end
    RST_L = 1'b0;
    #1;
    n_checks++;
    if ({WORD, VALID, OVERRUN, FRAME_ERR, BUSY} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected 000", {WORD, VALID, OVERRUN, FRAME_ERR, BUSY});
    end
    tick(1'b0, 1'b0);
    RST_L = 1'b1;
    tick(1'b1, 1'b0);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rst_first_idle: got %0b expected 0", BUSY);
    end
    tick(1'b1, 1'b1); send_bits(8'h0F, 1'b1); tick(1'b1, 1'b0);
    n_checks++;
    if ({WORD, VALID, OVERRUN} !== {8'h0F, 2'b10}) begin
      n_fail++; $display("FAIL rst_clean_word: got %h expected 03e", {WORD, VALID, OVERRUN});
    end
    ACK = 1'b1;
    tick(1'b0, 1'b0);
    ACK = 1'b0;
  endtask

  task automatic test_idle_line();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if ({BUSY, VALID, FRAME_ERR} !== 3'b000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_line: got %0d bad edges expected 0", bad);
    end
    tick(1'b0, 1'b1);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL idle_enb_low_start: got %0b expected 0", BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_frame_err();
    test_lsb_first();
    test_msb_gaps();
    test_overrun();
    test_reset_mid_frame();
    test_idle_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
